// File: rtl/switch_mcu_regfile_mp.sv
// Multi-port register file for the switch MCU core: two byte-enabled write ports
// (A wins per byte on a shared address), NUM_RD registered read ports, optional bypass.
module switch_mcu_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int RD_HOLD  = 0,
  parameter int ZERO_REG = 1
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic                       in_wen_a,
  input  logic [ADDR_W-1:0]          in_waddr_a,
  input  logic [DATA_W-1:0]          in_wdata_a,
  input  logic [DATA_W/8-1:0]        in_wbe_a,
  input  logic                       in_wen_b,
  input  logic [ADDR_W-1:0]          in_waddr_b,
  input  logic [DATA_W-1:0]          in_wdata_b,
  input  logic [DATA_W/8-1:0]        in_wbe_b,
  input  logic [NUM_RD-1:0]          in_ren,
  input  logic [NUM_RD*ADDR_W-1:0]   in_raddr,
  output logic [NUM_RD*DATA_W-1:0]   out_rdata,
  output logic                       out_wcollide
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0]        mem_q [DEPTH];
  logic [DATA_W-1:0]        mem_d [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
  logic                     wcollide_q, wcollide_d;
  logic                     eff_a, eff_b;
  logic [ADDR_W-1:0]        raddr;
  logic [DATA_W-1:0]        rval;

  // Writes: B first so that A overwrites every byte it enables on a shared address.
  always_comb begin
    eff_a = in_wen_a && (|in_wbe_a) && !((ZERO_REG != 0) && (in_waddr_a == '0));
    eff_b = in_wen_b && (|in_wbe_b) && !((ZERO_REG != 0) && (in_waddr_b == '0));
    wcollide_d = eff_a && eff_b && (in_waddr_a == in_waddr_b);
    mem_d = mem_q;
    for (int k = 0; k < NB; k++) begin
      if (eff_b && in_wbe_b[k]) mem_d[in_waddr_b][8*k +: 8] = in_wdata_b[8*k +: 8];
    end
    for (int k = 0; k < NB; k++) begin
      if (eff_a && in_wbe_a[k]) mem_d[in_waddr_a][8*k +: 8] = in_wdata_a[8*k +: 8];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    raddr   = '0;
    rval    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      raddr = in_raddr[p*ADDR_W +: ADDR_W];
      rval  = (BYPASS != 0) ? mem_d[raddr] : mem_q[raddr];
      if ((ZERO_REG != 0) && (raddr == '0)) rval = '0;
      if (in_ren[p]) begin
        rdata_d[p*DATA_W +: DATA_W] = rval;
      end else if (RD_HOLD == 0) begin
        rdata_d[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q    <= '0;
      wcollide_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rdata_q    <= rdata_d;
      wcollide_q <= wcollide_d;
    end
  end

  assign out_rdata    = rdata_q;
  assign out_wcollide = wcollide_q;

endmodule

// File: tb/tb_switch_mcu_regfile_mp.sv
// Bench for switch_mcu_regfile_mp: two instances (bypass/zero-on-disable and
// no-bypass/hold) checked every cycle against a per-address model plus literal pins.
module tb_switch_mcu_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen_a = 0, wen_b = 0;
  logic [4:0]  waddr_a = 0, waddr_b = 0;
  logic [31:0] wdata_a = 0, wdata_b = 0;
  logic [3:0]  wbe_a = 0, wbe_b = 0;
  logic [1:0]  ren = 0;
  logic [9:0]  raddr = 0;
  logic [63:0] rdata0, rdata1;
  logic        col0, col1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 0;

  logic [31:0] m_mem [2][32];
  logic [31:0] m_rd  [2][2];
  logic        m_col [2];
  bit          m_byp [2] = '{1'b1, 1'b0};
  bit          m_hold[2] = '{1'b0, 1'b1};

  always #5 clk = ~clk;

  switch_mcu_regfile_mp #(.BYPASS(1), .RD_HOLD(0)) dut0 (
    .in_clk(clk), .in_rst(rst),
    .in_wen_a(wen_a), .in_waddr_a(waddr_a), .in_wdata_a(wdata_a), .in_wbe_a(wbe_a),
    .in_wen_b(wen_b), .in_waddr_b(waddr_b), .in_wdata_b(wdata_b), .in_wbe_b(wbe_b),
    .in_ren(ren), .in_raddr(raddr), .out_rdata(rdata0), .out_wcollide(col0));

  switch_mcu_regfile_mp #(.BYPASS(0), .RD_HOLD(1)) dut1 (
    .in_clk(clk), .in_rst(rst),
    .in_wen_a(wen_a), .in_waddr_a(waddr_a), .in_wdata_a(wdata_a), .in_wbe_a(wbe_a),
    .in_wen_b(wen_b), .in_waddr_b(waddr_b), .in_wdata_b(wdata_b), .in_wbe_b(wbe_b),
    .in_ren(ren), .in_raddr(raddr), .out_rdata(rdata1), .out_wcollide(col1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value address a holds after this edge: old contents, then B's bytes, then A's bytes.
  function automatic logic [31:0] post_val(input int a, input logic [31:0] old);
    logic [31:0] v;
    v = old;
    if (a == 0) return 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (wen_b && waddr_b == a && wbe_b[k]) v[8*k +: 8] = wdata_b[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      if (wen_a && waddr_a == a && wbe_a[k]) v[8*k +: 8] = wdata_a[8*k +: 8];
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 32; a++) m_mem[i][a] <= 32'h0;
        m_rd[i][0] <= 32'h0;
        m_rd[i][1] <= 32'h0;
        m_col[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int a = 0; a < 32; a++) m_mem[i][a] <= post_val(a, m_mem[i][a]);
        for (int p = 0; p < 2; p++) begin
          if (ren[p])
            m_rd[i][p] <= m_byp[i] ? post_val(int'(raddr[p*5 +: 5]), m_mem[i][raddr[p*5 +: 5]])
                                   : m_mem[i][raddr[p*5 +: 5]];
          else if (!m_hold[i])
            m_rd[i][p] <= 32'h0;
        end
        m_col[i] <= wen_a && wen_b && (|wbe_a) && (|wbe_b) &&
                    (waddr_a == waddr_b) && (waddr_a != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("d0_lane0", rdata0[31:0],  m_rd[0][0]);
      chk("d0_lane1", rdata0[63:32], m_rd[0][1]);
      chk("d0_col",   {31'b0, col0}, {31'b0, m_col[0]});
      chk("d1_lane0", rdata1[31:0],  m_rd[1][0]);
      chk("d1_lane1", rdata1[63:32], m_rd[1][1]);
      chk("d1_col",   {31'b0, col1}, {31'b0, m_col[1]});
    end
  end

  task automatic idle();
    wen_a = 0; wen_b = 0; wbe_a = 0; wbe_b = 0; ren = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    ren[p] = 1'b1;
    raddr[p*5 +: 5] = a;
  endtask

  task automatic wa(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wen_a = 1; waddr_a = a; wdata_a = d; wbe_a = be;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wen_b = 1; waddr_b = a; wdata_b = d; wbe_b = be;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata0", rdata0[31:0], 32'h0);
    chk("rst_col0", {31'b0, col0}, 32'h0);
    rst = 1'b1;
    cmp_en = 1;

    // 1: read everything after reset
    for (int a = 0; a < 32; a++) begin
      idle(); rd(0, 5'(a)); rd(1, 5'(31 - a));
      step();
    end
    chk("t1_lane1", rdata0[63:32], 32'h0);

    // 2: byte-enable write
    idle(); wa(5, 32'h11223344, 4'hF); step();
    idle(); wa(5, 32'hAABBCCDD, 4'h5); step();
    idle(); rd(0, 5); step();
    chk("t2_d0", rdata0[31:0], 32'h11BB33DD);
    chk("t2_d1", rdata1[31:0], 32'h11BB33DD);

    // 3: collision, A keeps its bytes
    idle(); wa(7, 32'hAAAAAAAA, 4'h3); wb(7, 32'hBBBBBBBB, 4'hF); step();
    chk("t3_col_hi", {31'b0, col0}, 32'h1);
    idle(); step();
    chk("t3_col_lo", {31'b0, col0}, 32'h0);
    idle(); rd(1, 7); step();
    chk("t3_data", rdata0[63:32], 32'hBBBBAAAA);

    // back-to-back collisions keep the pulse high; different addresses write independently
    idle(); wa(9, 32'h01020304, 4'h1); wb(9, 32'h0A0B0C0D, 4'h2); step();
    idle(); wa(9, 32'h11111111, 4'h8); wb(9, 32'h22222222, 4'h8); step();
    chk("b2b_col", {31'b0, col1}, 32'h1);
    idle(); wa(10, 32'hCAFEF00D, 4'hF); wb(11, 32'h600DD00D, 4'hF); step();
    chk("b2b_col_end", {31'b0, col0}, 32'h0);
    idle(); rd(0, 10); rd(1, 11); step();
    chk("ind_a", rdata0[31:0], 32'hCAFEF00D);
    chk("ind_b", rdata1[63:32], 32'h600DD00D);
    idle(); rd(0, 9); step();
    chk("b2b_data", rdata0[31:0], 32'h11000C04);

    // 4: bypass vs no bypass
    idle(); wa(3, 32'h12345678, 4'hF); step();
    idle(); wa(3, 32'hDEADBEEF, 4'hF); rd(0, 3); step();
    chk("t4_byp", rdata0[31:0], 32'hDEADBEEF);
    chk("t4_nobyp", rdata1[31:0], 32'h12345678);
    idle(); rd(0, 3); step();
    chk("t4_nobyp_next", rdata1[31:0], 32'hDEADBEEF);

    // 5: zero register
    idle(); wa(0, 32'hFFFFFFFF, 4'hF); wb(0, 32'hFFFFFFFF, 4'hF); rd(1, 0); step();
    chk("t5_zero", rdata0[63:32], 32'h0);
    chk("t5_col", {31'b0, col0}, 32'h0);
    idle(); rd(1, 0); step();
    chk("t5_zero_d1", rdata1[63:32], 32'h0);

    // 6: read disable then asynchronous reset between edges
    idle(); rd(0, 5); step();
    chk("t6_read", rdata0[31:0], 32'h11BB33DD);
    idle(); step();
    chk("t6_zero_dis", rdata0[31:0], 32'h0);
    chk("t6_hold", rdata1[31:0], 32'h11BB33DD);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_d0", rdata0[31:0], 32'h0);
    chk("t6_rst_d1", rdata1[31:0], 32'h0);
    #1 rst = 1'b1;
    idle(); rd(0, 5); rd(1, 3); step();
    chk("t6_after_rst", rdata0[31:0], 32'h0);
    chk("t6_after_rst3", rdata1[63:32], 32'h0);

    idle(); step(); step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
